// File: rtl/uart_tx_arb_pkg.sv
// Shared constants for the arbitrated UART transmitter: FSM encodings,
// requester index width, baud divisors (12 MHz clock) and capture layout.
package uart_tx_arb_pkg;

  // Clock cycles per bit at 12 MHz
  localparam int B115200 = 104;
  localparam int B57600  = 208;
  localparam int B38400  = 313;
  localparam int B19200  = 625;
  localparam int B9600   = 1250;
  localparam int B4800   = 2500;
  localparam int B2400   = 5000;

  localparam int REQ_IDX_W = 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef logic [REQ_IDX_W-1:0] req_idx_t;

  typedef struct packed {
    req_idx_t   idx;
    logic [7:0] dat;
  } cap_t;

  // A lone requester always wins; on a tie the pointer names the winner.
  function automatic req_idx_t rr_pick(logic r0, logic r1, req_idx_t ptr);
    if (r0 && r1) return ptr;
    return r1 ? req_idx_t'(1) : req_idx_t'(0);
  endfunction

endpackage

// File: rtl/uart_tx_arb_tx.sv
// 8N1 serial transmitter, LSB first; start accepted only while idle, frame
// begins on tx one cycle after start. ready rises 2 cycles before stop ends.
module uart_tx
  import uart_tx_arb_pkg::*;
#(
  parameter int BAUDRATE = B115200
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int CW = $clog2(BAUDRATE);

  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic [8:0]    r_shift;
  logic          r_active;
  logic          r_tx;
  logic          w_bit_end;

  assign w_bit_end = (r_cnt == CW'(BAUDRATE - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '1;
      r_active <= 1'b0;
      r_tx     <= 1'b1;
    end else if (!r_active) begin
      if (start) begin
        r_active <= 1'b1;
        r_shift  <= {1'b1, data};
        r_tx     <= 1'b0;
        r_cnt    <= '0;
        r_bit    <= '0;
      end
    end else if (w_bit_end) begin
      r_cnt <= '0;
      if (r_bit == 4'd9) begin
        r_active <= 1'b0;
        r_tx     <= 1'b1;
        r_bit    <= '0;
      end else begin
        r_bit   <= r_bit + 4'd1;
        r_tx    <= r_shift[0];
        r_shift <= {1'b1, r_shift[8:1]};
      end
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Early ready lets the arbiter's DONE/IDLE cycles overlap the stop bit,
  // so back-to-back frames are separated by only 3 idle cycles.
  assign ready = !r_active || (r_bit == 4'd9 && r_cnt >= CW'(BAUDRATE - 2));
  assign tx    = r_tx;

endmodule

// File: rtl/uart_tx_arb.sv
// Two-requester UART transmitter; round-robin tie-break, or requester 0 fixed priority with UART_TX_ARB_FIXED_PRIO_EN.
// Req at edge k -> ack during cycle k+1 -> start bit from edge k+2; requesters hold req/data until ack.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int BAUDRATE = B115200
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       tx,
  output logic       busy
);

  logic [1:0] r_state;
  cap_t       r_cap;
  logic       r_ack0;
  logic       r_ack1;
  logic       r_start;
  logic       r_busy;
  req_idx_t   w_pick;
  logic       w_held;
  logic       w_ready;
  logic       w_tx;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
  assign w_pick = rr_pick(req0, req1, req_idx_t'(0));
`else
  req_idx_t r_ptr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr <= '0;
    end else if (r_state == ST_DONE) begin
      r_ptr <= ~r_cap.idx;
    end
  end

  assign w_pick = rr_pick(req0, req1, r_ptr);
`endif

  assign w_held = (r_cap.idx == req_idx_t'(1)) ? req1 : req0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_cap   <= '0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req0 || req1) begin
            r_cap.idx <= w_pick;
            r_cap.dat <= (w_pick == req_idx_t'(1)) ? data1 : data0;
            r_busy    <= 1'b1;
            r_state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // A request withdrawn before its ack is dropped without a frame
          if (w_held) begin
            r_ack0  <= (r_cap.idx == req_idx_t'(0));
            r_ack1  <= (r_cap.idx == req_idx_t'(1));
            r_start <= 1'b1;
            r_state <= ST_SEND;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_SEND: begin
          // r_start is still set on the edge the transmitter accepts it
          if (w_ready && !r_start) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  uart_tx #(
    .BAUDRATE(BAUDRATE)
  ) u_tx (
    .clk   (clk),
    .rstn  (rstn),
    .start (r_start),
    .data  (r_cap.dat),
    .tx    (w_tx),
    .ready (w_ready)
  );

  assign ack0 = r_ack0;
  assign ack1 = r_ack1;
  assign busy = r_busy;
  assign tx   = w_tx;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: line decoder plus ack monitor, checked against a
// grant-order model derived from the arbitration rules.
`timescale 1ns/1ps
module tb_uart_tx_arb;

  localparam int B     = 104;
  localparam int FRAME = 10 * B;

  logic clk = 1'b0, rstn = 1'b1, req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic ack0, ack1, tx, busy;

  int errors = 0, checks = 0, cyc = 0, aborted = 0;
  bit both_ack = 1'b0;
  int ack_idx_q[$], ack_cyc_q[$];
  int fr_byte_q[$], fr_start_q[$];
  bit fr_ok_q[$];
  int post0_q[$], post1_q[$];
  int m_last = 1;  // requester served last; reset behaves as if 1 was

  uart_tx_arb #(.BAUDRATE(B)) dut (
    .clk(clk), .rstn(rstn), .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, limit 2000000", $time);
    $fatal(1);
  end

  initial forever begin : ack_mon
    @(negedge clk);
    if (ack0 === 1'b1 && ack1 === 1'b1) both_ack = 1'b1;
    if (ack0 === 1'b1) begin ack_idx_q.push_back(0); ack_cyc_q.push_back(cyc); end
    else if (ack1 === 1'b1) begin ack_idx_q.push_back(1); ack_cyc_q.push_back(cyc); end
  end

  initial forever begin : line_dec
    @(negedge clk);
    if (rstn === 1'b1 && tx === 1'b0) begin
      logic [9:0] bits;
      bit ok, ab;
      int st;
      st = cyc; ok = 1'b1; ab = 1'b0; bits = '0;
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < B; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (rstn !== 1'b1) ab = 1'b1;
          if (ab) break;
          if (c == 0) bits[b] = tx;
          else if (tx !== bits[b]) ok = 1'b0;
        end
        if (ab) break;
      end
      if (ab) aborted++;
      else begin
        fr_ok_q.push_back(ok && bits[0] == 1'b0 && bits[9] == 1'b1);
        fr_byte_q.push_back(int'(bits[8:1]));
        fr_start_q.push_back(st);
      end
    end
  end

  function automatic int pick(bit r0, bit r1);
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    return r0 ? 0 : 1;
`else
    if (r0 && r1) return (m_last == 0) ? 1 : 0;
    return r0 ? 0 : 1;
`endif
  endfunction

  task automatic clear_logs;
    ack_idx_q.delete(); ack_cyc_q.delete();
    fr_byte_q.delete(); fr_start_q.delete(); fr_ok_q.delete();
    post0_q.delete(); post1_q.delete();
  endtask

  task automatic wait_idle(output int c, output bit to);
    to = 1'b1; c = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin c = cyc; to = 1'b0; break; end
    end
  endtask

  // Raise the chosen requests, drop each on its ack; with keep, re-arm with a
  // fresh byte until n acks have been collected.
  task automatic drive(input bit r0, input bit r1, input bit keep, input int n, output bit to);
    int got = 0;
    if (r0) post0_q.push_back(int'(data0));
    if (r1) post1_q.push_back(int'(data1));
    req0 = r0; req1 = r1;
    for (int i = 0; i < n * (FRAME + 20); i++) begin
      @(negedge clk);
      if (ack0 === 1'b1) begin
        got++;
        if (keep && got < n) begin data0 = 8'($urandom); post0_q.push_back(int'(data0)); end
        else req0 = 1'b0;
      end
      if (ack1 === 1'b1) begin
        got++;
        if (keep && got < n) begin data1 = 8'($urandom); post1_q.push_back(int'(data1)); end
        else req1 = 1'b0;
      end
      if (got >= n) break;
    end
    to = (got < n);
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_reset;
    req0 = 1'b0; req1 = 1'b0;
    #2 rstn = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx);
    if (tx !== 1'b1) errors++;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack0: got %b expected 0", ack0); end
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL reset_ack1: got %b expected 0", ack1); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single;
    int k, ack_c, fall; bit seen, to;
    clear_logs();
    @(negedge clk);
    rstn = 1'b1; data0 = 8'h41; req0 = 1'b1; k = cyc + 1; m_last = 1;
    seen = 1'b0; ack_c = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack0 === 1'b1) begin ack_c = cyc; seen = 1'b1; req0 = 1'b0; break; end
    end
    checks++; if (!seen || ack_c != k + 1) begin errors++; $display("FAIL single_ack_cycle: got %0d expected %0d", ack_c, k + 1); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_at_ack: got %b expected 1", busy); end
    @(negedge clk);
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL single_ack_width: got %b expected 0", ack0); end
    wait_idle(fall, to);
    checks++; if (to || fall != k + 2 + FRAME) begin errors++; $display("FAIL single_busy_fall: got %0d expected %0d", fall, k + 2 + FRAME); end
    @(negedge clk);
    checks++;
    if (fr_byte_q.size() != 1) begin errors++; $display("FAIL single_frames: got %0d expected 1", fr_byte_q.size()); end
    else begin
      checks++; if (fr_start_q[0] != k + 2) begin errors++; $display("FAIL single_start: got %0d expected %0d", fr_start_q[0], k + 2); end
      checks++; if (fr_byte_q[0] != 8'h41) begin errors++; $display("FAIL single_byte: got %0h expected 41", fr_byte_q[0]); end
      checks++; if (!fr_ok_q[0]) begin errors++; $display("FAIL single_framing: got bad expected clean"); end
    end
    m_last = 0;
  endtask

  task automatic test_rr_pair;
    int exp_idx[2], fall; bit to, to2;
    rstn = 1'b0; repeat (2) @(negedge clk); rstn = 1'b1; m_last = 1;
    clear_logs();
    data0 = 8'h30; data1 = 8'h31;
    exp_idx[0] = pick(1'b1, 1'b1); exp_idx[1] = 1 - exp_idx[0]; m_last = exp_idx[1];
    drive(1'b1, 1'b1, 1'b0, 2, to);
    wait_idle(fall, to2); @(negedge clk);
    checks++; if (to || to2) begin errors++; $display("FAIL pair_timeout: got timeout expected completion"); end
    checks++;
    if (ack_idx_q.size() != 2 || fr_byte_q.size() != 2) begin
      errors++; $display("FAIL pair_count: got %0d acks %0d frames expected 2", ack_idx_q.size(), fr_byte_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++; if (ack_idx_q[i] != exp_idx[i]) begin errors++; $display("FAIL pair_order[%0d]: got %0d expected %0d", i, ack_idx_q[i], exp_idx[i]); end
        checks++; if (fr_byte_q[i] != 8'h30 + exp_idx[i]) begin errors++; $display("FAIL pair_byte[%0d]: got %0h expected %0h", i, fr_byte_q[i], 8'h30 + exp_idx[i]); end
      end
    end
  endtask

  task automatic test_back_to_back;
    int exp_idx[4], eb, fall; bit to, to2;
    clear_logs();
    data0 = 8'($urandom); data1 = 8'($urandom);
    for (int i = 0; i < 4; i++) begin exp_idx[i] = pick(1'b1, 1'b1); m_last = exp_idx[i]; end
    drive(1'b1, 1'b1, 1'b1, 4, to);
    wait_idle(fall, to2); @(negedge clk);
    checks++; if (to || to2) begin errors++; $display("FAIL b2b_timeout: got timeout expected completion"); end
    checks++;
    if (ack_idx_q.size() != 4 || fr_byte_q.size() != 4) begin
      errors++; $display("FAIL b2b_count: got %0d acks %0d frames expected 4", ack_idx_q.size(), fr_byte_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        eb = (exp_idx[i] == 0) ? post0_q.pop_front() : post1_q.pop_front();
        checks++; if (ack_idx_q[i] != exp_idx[i]) begin errors++; $display("FAIL b2b_order[%0d]: got %0d expected %0d", i, ack_idx_q[i], exp_idx[i]); end
        checks++; if (fr_byte_q[i] != eb || !fr_ok_q[i]) begin errors++; $display("FAIL b2b_byte[%0d]: got %0h ok=%0d expected %0h ok=1", i, fr_byte_q[i], fr_ok_q[i], eb); end
        checks++; if (fr_start_q[i] != ack_cyc_q[i] + 1) begin errors++; $display("FAIL b2b_ack_to_start[%0d]: got %0d expected %0d", i, fr_start_q[i], ack_cyc_q[i] + 1); end
        if (i > 0) begin
          checks++;
          if (fr_start_q[i] - fr_start_q[i-1] != FRAME + 3) begin
            errors++; $display("FAIL b2b_gap[%0d]: got %0d idle cycles expected 3", i, fr_start_q[i] - fr_start_q[i-1] - FRAME);
          end
        end
      end
    end
  endtask

  task automatic test_late_request;
    int fall, ack1_c, d0, d1; bit got, to;
    clear_logs();
    data0 = 8'($urandom); d0 = int'(data0); req0 = 1'b1;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (ack0 === 1'b1) begin req0 = 1'b0; break; end end
    repeat (200) @(negedge clk);
    data1 = 8'($urandom); d1 = int'(data1); req1 = 1'b1;
    fall = -1; got = 1'b0; ack1_c = -1;
    for (int i = 0; i < FRAME + 50; i++) begin
      @(negedge clk);
      if (fall < 0 && busy === 1'b0) fall = cyc;
      if (ack1 === 1'b1) begin ack1_c = cyc; got = 1'b1; req1 = 1'b0; break; end
    end
    checks++; if (!got || fall < 0 || ack1_c != fall + 2) begin errors++; $display("FAIL late_ack1_cycle: got %0d expected %0d", ack1_c, fall + 2); end
    wait_idle(fall, to); @(negedge clk);
    checks++;
    if (to || fr_byte_q.size() != 2) begin errors++; $display("FAIL late_frames: got %0d expected 2", fr_byte_q.size()); end
    else begin
      checks++; if (fr_byte_q[0] != d0 || fr_byte_q[1] != d1) begin errors++; $display("FAIL late_bytes: got %0h %0h expected %0h %0h", fr_byte_q[0], fr_byte_q[1], d0, d1); end
    end
    m_last = 1;
    clear_logs();
    data0 = 8'($urandom); req0 = 1'b1;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (ack0 === 1'b1) begin req0 = 1'b0; break; end end
    repeat (300) @(negedge clk);
    data1 = 8'($urandom); req1 = 1'b1;
    repeat (300) @(negedge clk);
    req1 = 1'b0;
    wait_idle(fall, to); repeat (30) @(negedge clk);
    checks++; if (ack_idx_q.size() != 1) begin errors++; $display("FAIL drop_acks: got %0d expected 1", ack_idx_q.size()); end
    checks++; if (fr_byte_q.size() != 1) begin errors++; $display("FAIL drop_frames: got %0d expected 1", fr_byte_q.size()); end
    checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL drop_idle: got tx=%b busy=%b expected tx=1 busy=0", tx, busy); end
    m_last = 0;
  endtask

  task automatic test_cancel;
    bit low_seen = 1'b0;
    clear_logs();
    @(negedge clk); data0 = 8'($urandom); req0 = 1'b1;
    @(negedge clk); req0 = 1'b0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (tx !== 1'b1) low_seen = 1'b1; end
    checks++; if (ack_idx_q.size() != 0) begin errors++; $display("FAIL cancel_ack: got %0d acks expected 0", ack_idx_q.size()); end
    checks++; if (low_seen || fr_byte_q.size() != 0) begin errors++; $display("FAIL cancel_tx: got activity expected idle line"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_midframe;
    int ab0, d, fall; bit to, to2;
    clear_logs();
    ab0 = aborted;
    data1 = 8'($urandom); req1 = 1'b1;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (ack1 === 1'b1) begin req1 = 1'b0; break; end end
    repeat (501) @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midreset_now: got tx=%b busy=%b expected tx=1 busy=0", tx, busy); end
    repeat (3) @(negedge clk);
    rstn = 1'b1; m_last = 1;
    repeat (5) @(negedge clk);
    checks++; if (aborted != ab0 + 1 || fr_byte_q.size() != 0) begin errors++; $display("FAIL midreset_abort: got %0d aborts %0d frames expected 1 and 0", aborted - ab0, fr_byte_q.size()); end
    clear_logs();
    data0 = 8'($urandom); d = int'(data0);
    drive(1'b1, 1'b0, 1'b0, 1, to);
    wait_idle(fall, to2); repeat (20) @(negedge clk);
    checks++;
    if (to || to2 || fr_byte_q.size() != 1) begin errors++; $display("FAIL midreset_next: got %0d frames expected 1", fr_byte_q.size()); end
    else begin
      checks++; if (fr_byte_q[0] != d || !fr_ok_q[0]) begin errors++; $display("FAIL midreset_byte: got %0h ok=%0d expected %0h ok=1", fr_byte_q[0], fr_ok_q[0], d); end
    end
    m_last = 0;
  endtask

  task automatic test_random;
    int exp_idx[$], eb, fall, n; bit r0, r1, to, to2;
    for (int t = 0; t < 6; t++) begin
      clear_logs(); exp_idx.delete();
      r0 = 1'($urandom_range(0, 1)); r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r1 = 1'b1;
      data0 = 8'($urandom); data1 = 8'($urandom);
      exp_idx.push_back(pick(r0, r1)); m_last = exp_idx[0];
      if (r0 && r1) begin exp_idx.push_back(1 - exp_idx[0]); m_last = exp_idx[1]; end
      n = exp_idx.size();
      drive(r0, r1, 1'b0, n, to);
      wait_idle(fall, to2); repeat (3) @(negedge clk);
      checks++;
      if (to || to2 || ack_idx_q.size() != n || fr_byte_q.size() != n) begin
        errors++; $display("FAIL rand%0d_count: got %0d acks %0d frames expected %0d", t, ack_idx_q.size(), fr_byte_q.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          eb = (exp_idx[i] == 0) ? post0_q.pop_front() : post1_q.pop_front();
          checks++; if (ack_idx_q[i] != exp_idx[i]) begin errors++; $display("FAIL rand%0d_order[%0d]: got %0d expected %0d", t, i, ack_idx_q[i], exp_idx[i]); end
          checks++; if (fr_byte_q[i] != eb || !fr_ok_q[i]) begin errors++; $display("FAIL rand%0d_byte[%0d]: got %0h expected %0h", t, i, fr_byte_q[i], eb); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_pair();
    test_back_to_back();
    test_late_request();
    test_cancel();
    test_reset_midframe();
    test_random();
    checks++; if (both_ack) begin errors++; $display("FAIL ack_overlap: got both acks high expected never"); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
